program_loader: RTL

Byte-stream program loader that fills the CPU's 32-word instruction memory, which the fetch/decode stage then reads. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written to instruction memory at addresses 0..N-1. A checksum and an inter-byte timeout guard the load. While a load is active, `cpu_hold` keeps the CPU's PC and register writes frozen.

---
 rtl/program_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a framed byte stream (A5, N, 4*N data
// bytes, XOR checksum) and writes big-endian 32-bit words into instruction
// memory at addresses 0..N-1. It holds the CPU for the whole load.
module program_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_WORDS      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [4:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  START_BYTE = 8'hA5;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] k, k_d;
  logic [ADDR_W-1:0] n_last, n_last_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [31:0]       word, word_d;
  logic [7:0]        csum, csum_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_d;
  logic              in_ready_d, imem_we_d, cpu_hold_d, load_done_d, load_error_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;

  logic        accept;
  logic [31:0] word_shift;
  logic        count_ok;

  assign accept     = in_valid && in_ready;
  assign word_shift = {word[23:0], in_data};
  assign count_ok   = (in_data != 8'd0) && (32'(in_data) <= MAX_WORDS);

  // State and registered outputs; async reset returns everything to idle values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      k          <= '0;
      n_last     <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      n_last     <= n_last_d;
      byte_cnt   <= byte_cnt_d;
      word       <= word_d;
      csum       <= csum_d;
      tmo_cnt    <= tmo_d;
      in_ready   <= in_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_hold   <= cpu_hold_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    k_d          = k;
    n_last_d     = n_last;
    byte_cnt_d   = byte_cnt;
    word_d       = word;
    csum_d       = csum;
    tmo_d        = tmo_cnt;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_hold_d   = cpu_hold;
    load_done_d  = load_done;
    load_error_d = load_error;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && in_data == START_BYTE) begin
          state_d      = S_COUNT;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          k_d          = '0;
          csum_d       = '0;
          byte_cnt_d   = '0;
          tmo_d        = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          tmo_d = '0;
          if (count_ok) begin
            n_last_d   = ADDR_W'(in_data - 8'd1);
            byte_cnt_d = '0;
            state_d    = S_DATA;
          end else begin
            state_d = S_ERROR;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      S_DATA: begin
        if (accept) begin
          tmo_d      = '0;
          word_d     = word_shift;
          csum_d     = csum ^ in_data;
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = k;
            imem_wdata_d = word_shift;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      S_WRITE: begin
        // Index stops at N-1 so addresses never run past the last word
        if (k == n_last) begin
          state_d = S_CHECK;
        end else begin
          k_d     = k + ADDR_W'(1);
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (accept) begin
          tmo_d = '0;
          if (in_data == csum) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR) load_error_d = 1'b1;
    in_ready_d = (state_d != S_WRITE);
  end

endmodule
